display_framebuffer: RTL and testbench
======================================

Name: display_framebuffer

Overview:
Parametrised double-buffered framebuffer for the LED matrix display path. It succeeds the single-flip display memory.
- The writer always targets the back buffer; the scan-out reader always sees the front buffer.
- Buffer swap is requested by the writer and committed only at a scan frame boundary, giving tear-free updates.
- Adds per-channel write masking and a hardware clear engine that fills the back buffer with a constant.

Parameters:
rows, 8, display rows per buffer (≥2)
columns, 32, display columns per buffer (≥2)
channels, 3, colour channels per pixel
channel_width, 8, bits per channel; pixel width W = channels*channel_width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wen  input  1  write enable, back buffer
wrow  input  $clog2(rows)  write row
wcol  input  $clog2(columns)  write column
wdata  input  W  write pixel
wmask  input  channels  per-channel write enable (bit i covers wdata[i*channel_width +: channel_width])
rrow  input  $clog2(rows)  read row, front buffer
rcol  input  $clog2(columns)  read column, front buffer
rdata  output  W  read pixel
frame_end  input  1  one-cycle pulse from scan-out at the end of a frame
swap_req  input  1  one-cycle request to swap at the next frame_end
swap_pending  output  1  swap requested, not yet committed
swap_done  output  1  one-cycle pulse in the cycle after a commit
clear_req  input  1  one-cycle request to fill the back buffer
clear_value  input  W  fill pixel, sampled at clear start
clear_busy  output  1  clear engine active
front_sel  output  1  index of the current front buffer

Behaviour:
- Reset values: front_sel=0, swap_pending=0, swap_done=0, clear_busy=0, rdata=0. Memory contents are not reset.
- Storage is 2*rows*columns words of W bits.
- Physical address = {buffer, row, col}. Row and column out-of-range (≥rows or ≥columns): writes are dropped; reads return an undefined value that is stable (no X-propagation requirement).
- Read port:
  - Synchronous with 1-cycle latency: rdata in cycle n+1 = front[rrow,rcol] sampled at cycle n, using the front_sel value in effect at cycle n.
- Write port:
  - When wen=1 and clear_busy=0, channel i of back[wrow,wcol] is updated when wmask[i]=1; other channels are kept.
  - wen is ignored while clear_busy=1.
  - A read of the front buffer never observes a same-cycle write to the back buffer.
- Swap FSM, states IDLE and PENDING:
  - IDLE→PENDING on swap_req; swap_pending=1 in the following cycle.
  - PENDING commits when frame_end=1 and clear_busy=0. On commit: front_sel toggles, the FSM returns to IDLE, and swap_done pulses the next cycle.
  - swap_req and frame_end in the same cycle while IDLE: no commit; the swap waits for the next frame_end.
  - Repeated swap_req while PENDING has no effect (only one swap).
  - frame_end while IDLE does nothing.
  - A write in the commit cycle lands in the old back buffer, which becomes the new front.
- Clear engine, states IDLE and RUN:
  - On clear_req (while IDLE): latch clear_value, go to RUN, set clear_busy=1 from the next cycle.
  - RUN writes one full pixel per cycle to the back buffer, in row-major order from (0,0) to (rows-1, columns-1).
  - Duration is exactly rows*columns cycles. clear_busy falls in the cycle after the last write.
  - clear_req while RUN is ignored.
  - swap_req during RUN is accepted into PENDING; the commit waits for the first frame_end after clear_busy=0.
  - The clear target is fixed to the back buffer as of clear start. No swap can commit during RUN.
- rst mid-clear or mid-swap: both FSMs go to IDLE and front_sel=0. Partially cleared contents remain.

Decomposition:
- Shared package display_pkg holds:
  - pixel_t, a packed struct of channels × channel_width;
  - the address-width functions (row_bits, col_bits);
  - the default geometry constants rows=8, columns=32, channels=3, channel_width=8.
- Sub-module display_framebuffer_ram: simple dual-port RAM with per-channel write enable and registered read. It is inferred as block RAM.
- The swap and clear FSMs stay in the top level.

Test Plan:
- Write/read isolation:
  - After rst, write 24'hffffff to back (3,5). Reading front (3,5) returns the pre-existing value, not ffffff.
  - swap_req, then frame_end: swap_done pulses and front_sel=1. rdata at (3,5) = 24'hffffff one cycle after the address.
- Deferred swap: swap_req → swap_pending=1, front_sel unchanged across 10 cycles without frame_end. frame_end → front_sel toggles in that clock edge, swap_pending=0, swap_done=1 one cycle later.
- Mask: back (0,0) = 24'h123456. Write 24'haabbcc with wmask=3'b010. After swap, read returns 24'h12bb56.
- Clear:
  - clear_req with clear_value=24'h101010. clear_busy stays high exactly 256 cycles.
  - A wen issued mid-clear is dropped.
  - After swap, all 256 pixels read 24'h101010.
- Swap during clear: swap_req at clear cycle 10 and frame_end at cycle 50 → no swap. The first frame_end after clear_busy falls → front_sel toggles.
- Reset mid-operation: pulse rst at clear cycle 100 with a swap pending → clear_busy=0, swap_pending=0, front_sel=0, rdata=0 in the next cycle.

Source files
------------

// File: rtl/display_framebuffer_pkg.sv
// Shared types and geometry helpers for the double-buffered LED matrix framebuffer.
package display_pkg;

  localparam int ROWS_DEF          = 8;
  localparam int COLS_DEF          = 32;
  localparam int CHANNELS_DEF      = 3;
  localparam int CHANNEL_WIDTH_DEF = 8;

  typedef struct packed {
    logic [CHANNELS_DEF-1:0][CHANNEL_WIDTH_DEF-1:0] ch;
  } pixel_t;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  function automatic int row_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_framebuffer_if.sv
// Writer / scan-out / control bundle for the framebuffer.
interface display_framebuffer_if
  import display_pkg::*;
#(
  parameter int rows          = ROWS_DEF,
  parameter int columns       = COLS_DEF,
  parameter int channels      = CHANNELS_DEF,
  parameter int channel_width = CHANNEL_WIDTH_DEF
);
  localparam int W  = channels * channel_width;
  localparam int RB = row_bits(rows);
  localparam int CB = col_bits(columns);

  logic                wen;
  logic [RB-1:0]       wrow;
  logic [CB-1:0]       wcol;
  logic [W-1:0]        wdata;
  logic [channels-1:0] wmask;
  logic [RB-1:0]       rrow;
  logic [CB-1:0]       rcol;
  logic [W-1:0]        rdata;
  logic                frame_end;
  logic                swap_req;
  logic                swap_pending;
  logic                swap_done;
  logic                clear_req;
  logic [W-1:0]        clear_value;
  logic                clear_busy;
  logic                front_sel;

  modport master (
    output wen, wrow, wcol, wdata, wmask, rrow, rcol, frame_end, swap_req,
           clear_req, clear_value,
    input  rdata, swap_pending, swap_done, clear_busy, front_sel
  );

  modport slave (
    input  wen, wrow, wcol, wdata, wmask, rrow, rcol, frame_end, swap_req,
           clear_req, clear_value,
    output rdata, swap_pending, swap_done, clear_busy, front_sel
  );
endinterface

// File: rtl/display_framebuffer_ram.sv
// Simple dual-port RAM, per-channel write enables, registered read output.
module display_framebuffer_ram #(
  parameter int AW            = 9,
  parameter int channels      = 3,
  parameter int channel_width = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [channels-1:0]                     we,
  input  logic [AW-1:0]                           waddr,
  input  logic [channels-1:0][channel_width-1:0]  wdata,
  input  logic [AW-1:0]                           raddr,
  output logic [channels-1:0][channel_width-1:0]  rdata
);
  logic [channels-1:0][channel_width-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < channels; i++)
      if (we[i]) mem[waddr][i] <= wdata[i];
  end

  // Only the output register is reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered framebuffer: writer fills back buffer, scan-out reads front,
// swaps commit only on frame_end, and a clear engine fills the back buffer.
module display_framebuffer
  import display_pkg::*;
#(
  parameter int rows          = ROWS_DEF,
  parameter int columns       = COLS_DEF,
  parameter int channels      = CHANNELS_DEF,
  parameter int channel_width = CHANNEL_WIDTH_DEF
) (
  input logic                  clk,
  input logic                  rst,
  display_framebuffer_if.slave bus
);
  localparam int W  = channels * channel_width;
  localparam int RB = row_bits(rows);
  localparam int CB = col_bits(columns);
  // Address is {buffer,row,col}; depth equals 2*rows*columns for power-of-two geometry.
  localparam int AW = 1 + RB + CB;

  swap_state_t swap_st, swap_nx;
  clr_state_t  clr_st, clr_nx;

  logic          front_sel_q, swap_done_q, commit, clr_last, clr_buf;
  logic [RB-1:0] crow;
  logic [CB-1:0] ccol;
  logic [W-1:0]  clr_val, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr;
  logic [channels-1:0] ram_we;

  assign clr_last = (crow == RB'(rows - 1)) && (ccol == CB'(columns - 1));
  assign commit   = (swap_st == SWAP_PENDING) && bus.frame_end && (clr_st == CLR_IDLE);

  always_comb begin
    swap_nx = swap_st;
    case (swap_st)
      SWAP_IDLE:    if (bus.swap_req) swap_nx = SWAP_PENDING;
      SWAP_PENDING: if (commit)       swap_nx = SWAP_IDLE;
      default:      swap_nx = SWAP_IDLE;
    endcase
  end

  always_comb begin
    clr_nx = clr_st;
    case (clr_st)
      CLR_IDLE: if (bus.clear_req) clr_nx = CLR_RUN;
      CLR_RUN:  if (clr_last)      clr_nx = CLR_IDLE;
      default:  clr_nx = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swap_st     <= SWAP_IDLE;
      clr_st      <= CLR_IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      crow        <= '0;
      ccol        <= '0;
    end else begin
      swap_st     <= swap_nx;
      clr_st      <= clr_nx;
      swap_done_q <= commit;
      if (commit) front_sel_q <= ~front_sel_q;
      if (clr_st == CLR_IDLE) begin
        crow <= '0;
        ccol <= '0;
      end else if (ccol == CB'(columns - 1)) begin
        ccol <= '0;
        crow <= crow + 1'b1;
      end else begin
        ccol <= ccol + 1'b1;
      end
    end
  end

  // Target is whatever will be the back buffer once the clear starts,
  // including a swap committing on the same edge.
  always_ff @(posedge clk) begin
    if (clr_st == CLR_IDLE && bus.clear_req) begin
      clr_val <= bus.clear_value;
      clr_buf <= commit ? front_sel_q : ~front_sel_q;
    end
  end

  always_comb begin
    ram_we    = '0;
    ram_waddr = {~front_sel_q, bus.wrow, bus.wcol};
    ram_wdata = bus.wdata;
    if (clr_st == CLR_RUN) begin
      ram_we    = '1;
      ram_waddr = {clr_buf, crow, ccol};
      ram_wdata = clr_val;
    end else if (bus.wen && (32'(bus.wrow) < 32'(rows)) && (32'(bus.wcol) < 32'(columns))) begin
      ram_we = bus.wmask;
    end
  end

  display_framebuffer_ram #(
    .AW(AW), .channels(channels), .channel_width(channel_width)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({front_sel_q, bus.rrow, bus.rcol}),
    .rdata (ram_rdata)
  );

  assign bus.rdata        = ram_rdata;
  assign bus.front_sel    = front_sel_q;
  assign bus.swap_pending = (swap_st == SWAP_PENDING);
  assign bus.swap_done    = swap_done_q;
  assign bus.clear_busy   = (clr_st == CLR_RUN);
endmodule

// File: tb/tb_display_framebuffer.sv
// Directed bench for display_framebuffer with a read-data scoreboard and a buffer model.
module tb_display_framebuffer;
  logic clk = 1'b0;
  logic rst;
  int   nchecks = 0;
  int   nerr    = 0;
  int   n;

  logic [23:0] mdl [2][8][32];
  logic        fs_m;
  logic [23:0] sb [$];

  display_framebuffer_if #(.rows(8), .columns(32), .channels(3), .channel_width(8)) bus ();

  display_framebuffer #(.rows(8), .columns(32), .channels(3), .channel_width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] d,
                                        input logic [2:0] m);
    logic [23:0] r;
    r = old;
    for (int i = 0; i < 3; i++)
      if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic fill_back(input logic [23:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++)
        mdl[~fs_m][r][c] = v;
  endtask

  task automatic wr(input int r, input int c, input logic [23:0] d, input logic [2:0] m);
    bus.wen = 1'b1; bus.wrow = r[2:0]; bus.wcol = c[4:0]; bus.wdata = d; bus.wmask = m;
    mdl[~fs_m][r][c] = merge(mdl[~fs_m][r][c], d, m);
    tick();
    bus.wen = 1'b0;
  endtask

  task automatic rd(input string tag, input int r, input int c);
    bus.rrow = r[2:0]; bus.rcol = c[4:0];
    sb.push_back(mdl[fs_m][r][c]);
    tick();
    chk(tag, {8'h0, bus.rdata}, {8'h0, sb.pop_front()});
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("swap_pending_set", {31'h0, bus.swap_pending}, 32'd1);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    fs_m = ~fs_m;
    chk("swap_front_sel", {31'h0, bus.front_sel}, {31'h0, fs_m});
    chk("swap_pending_clr", {31'h0, bus.swap_pending}, 32'd0);
    chk("swap_done_pulse", {31'h0, bus.swap_done}, 32'd1);
    tick();
    chk("swap_done_low", {31'h0, bus.swap_done}, 32'd0);
  endtask

  task automatic do_clear(input logic [23:0] v);
    bus.clear_value = v; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.clear_busy && n < 1000) begin
      tick();
      n++;
    end
    fill_back(v);
    chk("clear_busy_len", n, 256);
  endtask

  initial begin
    rst = 1'b1; fs_m = 1'b0;
    bus.wen = 0; bus.wrow = 0; bus.wcol = 0; bus.wdata = 0; bus.wmask = 0;
    bus.rrow = 0; bus.rcol = 0; bus.frame_end = 0; bus.swap_req = 0;
    bus.clear_req = 0; bus.clear_value = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_front_sel", {31'h0, bus.front_sel}, 32'd0);
    chk("rst_pending", {31'h0, bus.swap_pending}, 32'd0);
    chk("rst_done", {31'h0, bus.swap_done}, 32'd0);
    chk("rst_busy", {31'h0, bus.clear_busy}, 32'd0);
    chk("rst_rdata", {8'h0, bus.rdata}, 32'd0);

    // Put both buffers into a known state.
    do_clear(24'h0);
    do_swap();
    do_clear(24'h0);

    // Back-buffer write is invisible on the front until swapped.
    wr(3, 5, 24'hffffff, 3'b111);
    rd("iso_front_old", 3, 5);
    do_swap();
    rd("iso_after_swap", 3, 5);

    // Same-cycle swap_req/frame_end, repeated swap_req, deferred commit.
    bus.swap_req = 1'b1; bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    chk("same_cyc_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    chk("same_cyc_pending", {31'h0, bus.swap_pending}, 32'd1);
    tick();
    bus.swap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("defer_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    end
    chk("defer_pending", {31'h0, bus.swap_pending}, 32'd1);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    fs_m = ~fs_m;
    chk("defer_commit_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    chk("defer_commit_pend", {31'h0, bus.swap_pending}, 32'd0);
    chk("defer_commit_done", {31'h0, bus.swap_done}, 32'd1);
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    chk("idle_fe_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    chk("idle_fe_done", {31'h0, bus.swap_done}, 32'd0);

    // Per-channel mask.
    wr(0, 0, 24'h123456, 3'b111);
    wr(0, 0, 24'haabbcc, 3'b010);
    do_swap();
    rd("mask_merge", 0, 0);
    chk("mask_literal", {8'h0, mdl[fs_m][0][0]}, 32'h0012bb56);

    // Write in the commit cycle lands in the new front.
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.frame_end = 1'b1;
    wr(1, 1, 24'habcdef, 3'b111);
    bus.frame_end = 1'b0;
    fs_m = ~fs_m;
    chk("commit_wr_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    rd("commit_wr_data", 1, 1);

    // Clear with a dropped write, swap request and an early frame_end.
    bus.clear_value = 24'h101010; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.clear_busy && n < 1000) begin
      bus.swap_req  = (n == 10);
      bus.frame_end = (n == 50);
      bus.wen = (n == 100); bus.wrow = 3'd2; bus.wcol = 5'd2;
      bus.wdata = 24'h777777; bus.wmask = 3'b111;
      tick();
      n++;
      if (n == 51) chk("clr_no_commit", {31'h0, bus.front_sel}, {31'h0, fs_m});
    end
    bus.swap_req = 1'b0; bus.frame_end = 1'b0; bus.wen = 1'b0;
    fill_back(24'h101010);
    chk("clr_busy_len", n, 256);
    chk("clr_pending", {31'h0, bus.swap_pending}, 32'd1);
    chk("clr_front_hold", {31'h0, bus.front_sel}, {31'h0, fs_m});
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    fs_m = ~fs_m;
    chk("clr_commit_front", {31'h0, bus.front_sel}, {31'h0, fs_m});
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 32; c++)
        rd("clr_pixel", r, c);

    // Reset in the middle of a clear with a swap pending.
    bus.clear_value = 24'h555555; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.swap_req = (i == 5);
      tick();
    end
    bus.swap_req = 1'b0;
    chk("pre_rst_busy", {31'h0, bus.clear_busy}, 32'd1);
    chk("pre_rst_pending", {31'h0, bus.swap_pending}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fs_m = 1'b0;
    chk("mid_rst_busy", {31'h0, bus.clear_busy}, 32'd0);
    chk("mid_rst_pending", {31'h0, bus.swap_pending}, 32'd0);
    chk("mid_rst_front", {31'h0, bus.front_sel}, 32'd0);
    chk("mid_rst_rdata", {8'h0, bus.rdata}, 32'd0);
    tick();
    chk("post_rst_busy", {31'h0, bus.clear_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
